// File: rtl/bcd_display_counter_if.sv
// Bus bundle for the BCD display counter. The board side is the master and the counter is the slave.
// Signal names follow the board pin naming used by the counter.
interface bcd_display_counter_if #(
    parameter int DIGITS = 2
);
    logic                  EN;
    logic                  UP;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LOAD_VAL;
    logic [4*DIGITS-1:0]   COUNT;
    logic [7*DIGITS-1:0]   HEX;
    logic                  TICK;
    logic                  WRAP;

    modport master (
        output EN, UP, LOAD, LOAD_VAL,
        input  COUNT, HEX, TICK, WRAP
    );

    modport slave (
        input  EN, UP, LOAD, LOAD_VAL,
        output COUNT, HEX, TICK, WRAP
    );
endinterface

// File: rtl/bcd_display_counter.sv
// Multi-digit BCD up/down counter advanced by a prescaler tick, with a registered
// active-low 7-segment decode per digit and optional leading-zero blanking.
module bcd_display_counter #(
    parameter int DIGITS    = 2,
    parameter int TICK_DIV  = 50000000,
    parameter int MAX_COUNT = 99,
    parameter int BLANK_LZ  = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    bcd_display_counter_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int value);
        logic [4*DIGITS-1:0] r;
        int v;
        v = value;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [7*DIGITS-1:0] hex_reset_val(input bit blank);
        logic [7*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[7*i +: 7] = (blank && i > 0) ? 7'b1111111 : 7'b0000001;
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MAX_COUNT);
    localparam logic [7*DIGITS-1:0] HEX_RST = hex_reset_val(BLANK_LZ != 0);

    logic [PW-1:0]         presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic                  wrap_q, wrap_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic [7*DIGITS-1:0]   hex_q, hex_d;

    logic [4*DIGITS-1:0]   count_inc, count_dec, load_clamp;
    logic [DIGITS-1:0]     inc_carry, dec_borrow;
    logic [DIGITS:1]       zero_above;

    assign inc_carry[0]       = 1'b1;
    assign dec_borrow[0]      = 1'b1;
    assign zero_above[DIGITS] = 1'b1;

    // Per-digit ripple carry/borrow, load clamp and segment decode.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            logic [3:0] ld_digit;
            assign digit    = count_q[4*gi +: 4];
            assign ld_digit = bus.LOAD_VAL[4*gi +: 4];

            assign count_inc[4*gi +: 4] = !inc_carry[gi] ? digit :
                                          (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            assign count_dec[4*gi +: 4] = !dec_borrow[gi] ? digit :
                                          (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            assign load_clamp[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;

            if (gi < DIGITS - 1) begin : g_chain
                assign inc_carry[gi+1]  = inc_carry[gi]  & (digit == 4'd9);
                assign dec_borrow[gi+1] = dec_borrow[gi] & (digit == 4'd0);
            end

            if (gi > 0) begin : g_blank
                assign zero_above[gi] = zero_above[gi+1] & (digit == 4'd0);
                assign hex_d[7*gi +: 7] = (BLANK_LZ != 0 && zero_above[gi]) ? 7'b1111111
                                                                             : seg7(digit);
            end else begin : g_lsd
                assign hex_d[6:0] = seg7(digit);
            end
        end
    endgenerate

    // Packed BCD orders like the decimal value, so plain compares are valid here.
    always_comb begin
        presc_d = presc_q + PW'(1);
        tick_d  = 1'b0;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end
        if (bus.LOAD) begin
            presc_d = '0;
            tick_d  = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.LOAD) begin
            count_d = (load_clamp > MAX_BCD) ? MAX_BCD : load_clamp;
        end else if (tick_q && bus.EN) begin
            if (bus.UP) begin
                if (count_q == MAX_BCD) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_BCD;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_dec;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            count_q <= '0;
            hex_q   <= HEX_RST;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            count_q <= count_d;
            hex_q   <= hex_d;
        end
    end

    assign bus.COUNT = count_q;
    assign bus.HEX   = hex_q;
    assign bus.TICK  = tick_q;
    assign bus.WRAP  = wrap_q;
endmodule

// File: tb/tb_bcd_display_counter.sv
// Scoreboard bench for bcd_display_counter (2 digits, divide-by-4 tick, modulo 60),
// with a second instance that blanks leading zeros and shares the same stimulus.
module tb_bcd_display_counter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_display_counter_if #(.DIGITS(2)) ifa ();
    bcd_display_counter_if #(.DIGITS(2)) ifb ();

    assign ifb.EN       = ifa.EN;
    assign ifb.UP       = ifa.UP;
    assign ifb.LOAD     = ifa.LOAD;
    assign ifb.LOAD_VAL = ifa.LOAD_VAL;

    bcd_display_counter #(.DIGITS(2), .TICK_DIV(4), .MAX_COUNT(59), .BLANK_LZ(0)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (ifa)
    );

    bcd_display_counter #(.DIGITS(2), .TICK_DIV(4), .MAX_COUNT(59), .BLANK_LZ(1)) dut_b (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (ifb)
    );

    typedef struct {
        logic [7:0] cnt;
        logic       wrap;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         mdl = 0;
    logic [7:0] prev_obs = 8'h00;
    logic [7:0] prev_exp = 8'h00;
    int         cyc = 0;
    int         last_tick = -1;
    int         tick_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_load(input logic [7:0] lv);
        int hi, lo, v;
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        v  = hi * 10 + lo;
        return (v > 59) ? 59 : v;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] hex_exp(input logic [7:0] c, input bit blank);
        logic [6:0] hi;
        hi = (blank && c[7:4] == 4'd0) ? 7'b1111111 : seg(c[7:4]);
        return {hi, seg(c[3:0])};
    endfunction

    // Runs after every edge: HEX lags the expected count by one cycle, TICK period,
    // and every COUNT/WRAP update is matched against the oldest queued expectation.
    task automatic monitor();
        exp_t e;
        cyc++;
        check("hex_a", 32'(ifa.HEX), 32'(hex_exp(prev_exp, 1'b0)));
        check("hex_b", 32'(ifb.HEX), 32'(hex_exp(prev_exp, 1'b1)));
        check("count_b", 32'(ifb.COUNT), 32'(bcd(mdl)));
        if (ifa.TICK === 1'b1) begin
            tick_seen++;
            if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'd4);
            last_tick = cyc;
        end
        if (ifa.COUNT !== prev_obs || ifa.WRAP !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_update", {23'd0, ifa.COUNT, ifa.WRAP}, {23'd0, prev_obs, 1'b0});
            end else begin
                e = sb.pop_front();
                check("count", 32'(ifa.COUNT), 32'(e.cnt));
                check("wrap", 32'(ifa.WRAP), 32'(e.wrap));
                $display("txn cyc=%0d count=%h wrap=%b exp_count=%h exp_wrap=%b",
                         cyc, ifa.COUNT, ifa.WRAP, e.cnt, e.wrap);
            end
        end
        prev_obs = ifa.COUNT;
        prev_exp = bcd(mdl);
    endtask

    // Drives one cycle of inputs, queues the update they should cause, then steps the clock.
    task automatic cycle(input bit en, input bit up, input bit load, input logic [7:0] lv);
        bit tick_now;
        int nv;
        tick_now     = (ifa.TICK === 1'b1);
        ifa.EN       = en;
        ifa.UP       = up;
        ifa.LOAD     = load;
        ifa.LOAD_VAL = lv;
        if (load) begin
            nv = clamp_load(lv);
            if (nv != mdl) sb.push_back('{bcd(nv), 1'b0});
            mdl       = nv;
            last_tick = -1;
        end else if (tick_now && en) begin
            if (up) begin
                if (mdl == 59) begin nv = 0; sb.push_back('{bcd(nv), 1'b1}); end
                else begin nv = mdl + 1; sb.push_back('{bcd(nv), 1'b0}); end
            end else begin
                if (mdl == 0) begin nv = 59; sb.push_back('{bcd(nv), 1'b1}); end
                else begin nv = mdl - 1; sb.push_back('{bcd(nv), 1'b0}); end
            end
            mdl = nv;
        end
        @(posedge clk);
        #1;
        monitor();
    endtask

    initial begin
        rst          = 1'b1;
        ifa.EN       = 1'b0;
        ifa.UP       = 1'b0;
        ifa.LOAD     = 1'b0;
        ifa.LOAD_VAL = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(ifa.COUNT), 32'h00);
        check("rst_tick", 32'(ifa.TICK), 32'd0);
        check("rst_wrap", 32'(ifa.WRAP), 32'd0);
        check("rst_hex_a", 32'(ifa.HEX), 32'({7'b0000001, 7'b0000001}));
        check("rst_hex_b", 32'(ifb.HEX), 32'({7'b1111111, 7'b0000001}));
        rst = 1'b0;

        // Free-running up count from zero.
        for (int i = 0; i < 44; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("t1_count", 32'(ifa.COUNT), 32'h10);

        // Load 58, count up through the 59 -> 00 wrap.
        cycle(1'b1, 1'b1, 1'b1, 8'h58);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("t2_count", 32'(ifa.COUNT), 32'h00);

        // Down count from zero wraps to 59, then 58.
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("t3_count", 32'(ifa.COUNT), 32'h58);

        // Load clamping: per-digit to 9, then to the terminal value.
        cycle(1'b0, 1'b0, 1'b1, 8'h7A);
        check("t4_clamp_max", 32'(ifa.COUNT), 32'h59);
        cycle(1'b0, 1'b0, 1'b1, 8'h3F);
        check("t4_clamp_digit", 32'(ifa.COUNT), 32'h39);

        // Paused: ticks keep coming, count holds.
        tick_seen = 0;
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("t5_ticks_paused", 32'(tick_seen), 32'd3);
        check("t5_frozen", 32'(ifa.COUNT), 32'h39);

        // Load issued while TICK is high takes priority over the step.
        for (int i = 0; i < 8 && ifa.TICK !== 1'b1; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("t5_tick_wait", 32'(ifa.TICK), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 8'h21);
        check("t5_load_wins", 32'(ifa.COUNT), 32'h21);

        // Load on the prescaler terminal cycle suppresses the tick.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h21);
        check("t5_tick_suppressed", 32'(ifa.TICK), 32'd0);

        // Leading-zero blanking on the second instance.
        cycle(1'b0, 1'b1, 1'b1, 8'h05);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("t6_hex_blank", 32'(ifb.HEX), 32'({7'b1111111, 7'b0100100}));
        check("t6_hex_noblank", 32'(ifa.HEX), 32'({7'b0000001, 7'b0100100}));

        // Asynchronous reset while a tick is pending.
        for (int i = 0; i < 8 && ifa.TICK !== 1'b1; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("t6_tick_wait", 32'(ifa.TICK), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_count", 32'(ifa.COUNT), 32'h00);
        check("t6_rst_tick", 32'(ifa.TICK), 32'd0);
        check("t6_rst_hex_b", 32'(ifb.HEX), 32'({7'b1111111, 7'b0000001}));
        sb.delete();
        mdl       = 0;
        prev_obs  = 8'h00;
        prev_exp  = 8'h00;
        last_tick = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("t6_after_rst", 32'(ifa.COUNT), 32'h01);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
